// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and timing constants for cook-time entry
package microwave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_REPEAT  = 2'd2
   } btn_state_e;

   localparam int MS_PER_S = 1000;

   // Cycles per millisecond: the clock rate (per second) divided down to one millisecond.
   function automatic int cpm(input int clk_freq_hz);
      return clk_freq_hz / MS_PER_S;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - one-cycle tick every millisecond, restartable to align with a press
module ms_tick_gen
   import microwave_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CPM = cpm(CLK_FREQ_HZ);
   localparam int PW  = (CPM > 1) ? $clog2(CPM) : 1;
   localparam logic [PW-1:0] P_TERM = PW'(CPM - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   // Tick on the last prescaler count; clearing restarts a full millisecond from zero.
   assign tick = (pre_q == P_TERM);

   always_comb begin
      pre_d = pre_q + 1'b1;
      if (clr || tick) begin
         pre_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/btn_hold_classifier.sv
// rtl/btn_hold_classifier.sv - classifies debounced presses as short, long or auto-repeat
module btn_hold_classifier
   import microwave_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   input  logic p_edge,
   input  logic n_edge,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic holding
);

   localparam int CPM    = cpm(CLK_FREQ_HZ);
   localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int MW     = $clog2(MS_MAX + 1);
   localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
   localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);

   if (CPM < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_params
      $error("btn_hold_classifier: CPM, LONG_MS and REPEAT_MS must all be >= 1");
   end

   btn_state_e    state_q;
   logic [MW-1:0] ms_q;
   logic          short_q;
   logic          long_q;
   logic          rep_q;
   logic          hold_q;
   logic          tick;
   logic          press_start;

   assign press_start = (state_q == ST_IDLE) && p_edge && !n_edge;

   ms_tick_gen #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .clr (press_start),
      .tick(tick)
   );

   // Release (n_edge) is checked before the threshold so it wins a same-cycle collision;
   // a level drop without n_edge means the upstream stage was reset, so leave silently.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ms_q    <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (press_start) begin
                  state_q <= ST_PRESSED;
                  ms_q    <= '0;
                  hold_q  <= 1'b1;
               end
            end
            ST_PRESSED: begin
               if (n_edge) begin
                  state_q <= ST_IDLE;
                  short_q <= 1'b1;
                  hold_q  <= 1'b0;
               end else if (!level) begin
                  state_q <= ST_IDLE;
                  hold_q  <= 1'b0;
               end else if (tick) begin
                  if (ms_q == LONG_LAST) begin
                     state_q <= ST_REPEAT;
                     long_q  <= 1'b1;
                     ms_q    <= '0;
                  end else begin
                     ms_q <= ms_q + 1'b1;
                  end
               end
            end
            ST_REPEAT: begin
               if (n_edge || !level) begin
                  state_q <= ST_IDLE;
                  hold_q  <= 1'b0;
               end else if (tick) begin
                  if (ms_q == REP_LAST) begin
                     rep_q <= 1'b1;
                     ms_q  <= '0;
                  end else begin
                     ms_q <= ms_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               hold_q  <= 1'b0;
            end
         endcase
      end
   end

   assign short_press  = short_q;
   assign long_press   = long_q;
   assign repeat_pulse = rep_q;
   assign holding      = hold_q;

endmodule
